md_unit: RTL



---
 rtl/md_pkg.sv | 26 ++
 rtl/md_compute.sv | 66 ++++++
 rtl/md_unit.sv | 86 ++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// small op-classification helpers also used by the main decoder.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // Multi-cycle ops are the four arithmetic codes; mthi/mtlo complete at once.
  function automatic logic isLongOp(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational HI/LO result generator for mult/multu/div/divu, including the
// divide-by-zero and most-negative / -1 special cases.
module md_compute
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic signed [2*WIDTH-1:0] prodS;
  logic        [2*WIDTH-1:0] prodU;
  logic signed [WIDTH-1:0]   quotS;
  logic signed [WIDTH-1:0]   remS;
  logic                      divByZero;
  logic                      signedOvf;

  assign prodS = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
  assign prodU = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  assign quotS = $signed(A) / $signed(B);
  assign remS  = $signed(A) % $signed(B);

  assign divByZero = (B == '0);
  assign signedOvf = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (&B);

  // Special cases are selected ahead of the raw quotient so an undefined
  // hardware divide result never reaches HI/LO.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prodS;
      MD_MULTU: {res_hi, res_lo} = prodU;
      MD_DIV: begin
        if (divByZero) begin
          res_hi = A;
          res_lo = '1;
        end else if (signedOvf) begin
          res_hi = '0;
          res_lo = A;
        end else begin
          res_hi = remS;
          res_lo = quotS;
        end
      end
      MD_DIVU: begin
        if (divByZero) begin
          res_hi = A;
          res_lo = '1;
        end else begin
          res_hi = A % B;
          res_lo = A / B;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: captures the result at start, holds busy for
// the configured latency, then commits it into the HI/LO registers.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] pendHi_q, pendLo_q;
  logic [WIDTH-1:0] resHi, resLo;
  logic             launch, commit;

  md_compute #(.WIDTH(WIDTH)) u_compute (
    .op     (op),
    .A      (A),
    .B      (B),
    .res_hi (resHi),
    .res_lo (resLo)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = BUSY;
      BUSY:    if (commit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Starts are only honoured from IDLE, so a stray start while busy is inert.
  always_comb begin
    busy   = (state_q == BUSY);
    launch = (state_q == IDLE) && start && isLongOp(op);
    commit = (state_q == BUSY) && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      pendHi_q <= '0;
      pendLo_q <= '0;
      cnt_q    <= '0;
    end else if (launch) begin
      pendHi_q <= resHi;
      pendLo_q <= resLo;
      cnt_q    <= isDivOp(op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
    end else if (commit) begin
      hi_q <= pendHi_q;
      lo_q <= pendLo_q;
    end else if (busy) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (start && (op == MD_MTHI)) begin
      hi_q <= A;
    end else if (start && (op == MD_MTLO)) begin
      lo_q <= A;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
